// File: rtl/muldiv_pkg.sv
// Shared RV32M multiply/divide definitions: funct3/funct7 encodings, sequencer
// states and the operand-signedness rules used at capture.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // R-type funct7 that routes an instruction to this unit instead of the ALU
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic a_is_signed(input logic [2:0] f);
    return f inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f);
    return f inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one radix-2 shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, signs fixed at the end.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CW-1:0]    count;
  logic [2:0]       op;
  logic             neg_a, neg_b, div_zero, div_ovf;
  // hi:lo is the product register for multiply, remainder:quotient for divide;
  // d holds the multiplicand or divisor magnitude.
  logic [WIDTH-1:0] hi, lo, d;

  // Capture-side decode
  logic             in_neg_a, in_neg_b, in_is_div;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    in_is_div = funct3[2];
    in_neg_a  = a_is_signed(funct3) & a[WIDTH-1];
    in_neg_b  = b_is_signed(funct3) & b[WIDTH-1];
    a_mag     = in_neg_a ? -a : a;
    b_mag     = in_neg_b ? -b : b;
  end

  // One iteration of each algorithm
  logic [WIDTH:0] sum, shifted, diff;

  always_comb begin
    sum     = {1'b0, hi} + {1'b0, (lo[0] ? d : '0)};
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, d};
  end

  // Sign fix and result selection from the final register contents
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, final_res;

  always_comb begin
    prod = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
    quo  = (neg_a ^ neg_b) ? -lo : lo;
    rem  = neg_a ? -hi : hi;
    // b=0 leaves quotient all ones and remainder |a| in the registers; only
    // the sign fix has to be suppressed on the quotient.
    if (div_zero) quo = '1;
    if (div_ovf) begin
      quo = MOST_NEG;
      rem = '0;
    end
    unique case (op)
      F3_MUL:                       final_res = prod[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:              final_res = quo;
      default:                      final_res = rem;
    endcase
  end

  // NOTE: every register here, datapath included, is async-reset so a reset
  // mid-operation leaves no stale operand state visible to the next request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      count    <= '0;
      op       <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      d        <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every read below sees the
      // pre-edge value regardless of statement order.
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !kill) begin
            op       <= funct3;
            neg_a    <= in_neg_a;
            neg_b    <= in_neg_b;
            div_zero <= in_is_div && (b == '0);
            div_ovf  <= in_is_div && !funct3[0] && (a == MOST_NEG) && (b == '1);
            hi       <= '0;
            lo       <= in_is_div ? a_mag : b_mag;
            d        <= in_is_div ? b_mag : a_mag;
            count    <= '0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (kill) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (count == LAST) begin
            result <= final_res;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            count <= count + 1'b1;
            if (op[2]) begin
              if (!diff[WIDTH]) begin
                hi <= diff[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], 1'b1};
              end else begin
                hi <= shifted[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], 1'b0};
              end
            end else begin
              hi <= sum[WIDTH:1];
              lo <= {sum[0], lo[WIDTH-1:1]};
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues expected results from an
// arithmetic reference model, an independent monitor checks each done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   funct3 = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         kill = 1'b0;
  logic         busy, done;
  logic [W-1:0] result;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .a(a), .b(b),
    .kill(kill), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
    logic [2:0]   f;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: RV32M semantics from plain 64-bit arithmetic
  function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    case (f)
      F3_MUL:    begin p = sx * sy; return p[31:0];  end
      F3_MULH:   begin p = sx * sy; return p[63:32]; end
      F3_MULHSU: begin p = sx * longint'(uy); return p[63:32]; end
      F3_MULHU:  begin p = ux * uy; return p[63:32]; end
      F3_DIV:    begin
        if (y == 0) return '1;
        if (x == MINV && y == '1) return x;
        p = sx / sy; return p[31:0];
      end
      F3_DIVU:   return (y == 0) ? '1 : x / y;
      F3_REM:    begin
        if (y == 0) return x;
        if (x == MINV && y == '1) return '0;
        p = sx % sy; return p[31:0];
      end
      default:   return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check($sformatf("result_f%0d", e.f), result, e.res);
        check("latency", W'(cyc - e.cyc), W'(W + 1));
      end
    end
  end

  // Issue one op; records the sampling edge in the queued expectation
  task automatic issue(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    @(negedge clk);
    start = 1'b1; funct3 = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    e.res = model(f, x, y); e.cyc = cyc; e.f = f;
    q.push_back(e);
  endtask

  // Wait (bounded) for the next done pulse, counting busy cycles on the way
  task automatic wait_done(output int busy_n);
    int seen;
    seen = done_cnt;
    busy_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (done_cnt != seen) return;
      if (busy) busy_n++;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    int bn;
    issue(f, x, y);
    wait_done(bn);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return MINV;
      3:       return 32'h7FFF_FFFF;
      4:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bn;
    #1;
    check("reset_busy", W'(busy), 32'd0);
    check("reset_done", W'(done), 32'd0);
    check("reset_result", result, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed cases, including busy-duration on the first one
    issue(F3_MUL, 32'd7, 32'hFFFF_FFFD);
    wait_done(bn);
    check("busy_cycles", W'(bn), W'(W + 1));
    run_op(F3_MULH,   MINV, MINV);
    run_op(F3_MULHU,  '1, '1);
    run_op(F3_MULHSU, '1, 32'd2);
    run_op(F3_DIV,    -32'sd7, 32'd2);
    run_op(F3_REM,    -32'sd7, 32'd2);
    run_op(F3_DIVU,   32'd100, 32'd7);
    run_op(F3_REMU,   32'd100, 32'd7);
    run_op(F3_DIVU,   32'd5, '0);
    run_op(F3_REMU,   32'd5, '0);
    run_op(F3_DIV,    -32'sd5, '0);
    run_op(F3_REM,    -32'sd5, '0);
    run_op(F3_DIV,    MINV, '1);
    run_op(F3_REM,    MINV, '1);

    // Start while busy is ignored
    issue(F3_MUL, 32'd3, 32'd4);
    repeat (8) @(negedge clk);
    start = 1'b1; funct3 = F3_MUL; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(bn);

    // Kill mid-operation: no done, result and busy settle
    issue(F3_MUL, 32'd5, 32'd5);
    void'(q.pop_back());
    repeat (3) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    @(negedge clk);
    check("kill_busy", W'(busy), 32'd0);
    check("kill_result", result, 32'd12);
    repeat (40) @(negedge clk);

    // Kill with start in idle drops the start
    @(negedge clk); kill = 1'b1; start = 1'b1; funct3 = F3_DIVU; a = 32'd8; b = 32'd2;
    @(negedge clk); kill = 1'b0; start = 1'b0;
    check("kill_start_busy", W'(busy), 32'd0);
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-divide
    issue(F3_DIV, 32'd1000, 32'd7);
    void'(q.pop_back());
    repeat (14) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", W'(busy), 32'd0);
    check("arst_done", W'(done), 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk); reset = 1'b0;
    run_op(F3_DIVU, 32'd10, 32'd3);

    // Randomised operations
    for (int i = 0; i < 200; i++)
      run_op(3'($urandom_range(0, 7)), pick(), pick());

    repeat (3) @(negedge clk);
    check("queue_empty", W'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
